// File: rtl/dmem_access_master.sv
// dmem_access_master: turns CPU byte/halfword/word loads and stores into
// word-only dmem accesses. Sub-word stores are done as read-modify-write, and
// the pipeline is stalled through req_ready while a request is in flight.
module dmem_access_master #(
    parameter int WADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic               ram_ena,
    output logic               wena,
    output logic [WADDR_W-1:0] addr,
    output logic [31:0]        data_in,
    input  logic [31:0]        data_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t               state_q, state_d;
    logic                 reqWe_q;
    logic [1:0]           reqSize_q;
    logic                 reqSigned_q;
    logic [WADDR_W-1:0]   wordAddr_q;
    logic [1:0]           byteOff_q;
    logic [31:0]          reqWdata_q;
    logic                 reqErr_q;
    logic [31:0]          rdWord_q;

    logic                 accept;
    logic                 misaligned;
    logic                 memAccess;
    logic [7:0]           loadByte;
    logic [15:0]          loadHalf;
    logic [31:0]          loadData;
    logic [31:0]          mergedWord;
    logic                 unusedAddrBits;

    // Address bits above the dmem range are dropped, so the address wraps.
    assign unusedAddrBits = ^req_addr[31:WADDR_W+2];

    assign accept = req_valid && req_ready;

    // Alignment check on the live request; size 11 is always an error.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Next-state logic: errors skip memory, word stores skip the read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_d = RESP;
                    end else if (req_we && req_size == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = reqWe_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, request capture on accept and read-word capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            reqWe_q     <= 1'b0;
            reqSize_q   <= 2'b00;
            reqSigned_q <= 1'b0;
            wordAddr_q  <= '0;
            byteOff_q   <= 2'b00;
            reqWdata_q  <= 32'h0;
            reqErr_q    <= 1'b0;
            rdWord_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                reqWe_q     <= req_we;
                reqSize_q   <= req_size;
                reqSigned_q <= req_signed;
                wordAddr_q  <= req_addr[WADDR_W+1:2];
                byteOff_q   <= req_addr[1:0];
                reqWdata_q  <= req_wdata;
                reqErr_q    <= misaligned;
            end
            if (state_q == READ) begin
                rdWord_q <= data_out;
            end
        end
    end

    // Little-endian lane pick for loads from the captured word.
    assign loadByte = rdWord_q[{byteOff_q, 3'b000} +: 8];
    assign loadHalf = rdWord_q[{byteOff_q[1], 4'b0000} +: 16];

    // Sign or zero extension of the selected lane.
    always_comb begin
        loadData = rdWord_q;
        case (reqSize_q)
            2'b00:   loadData = reqSigned_q ? {{24{loadByte[7]}}, loadByte} : {24'h0, loadByte};
            2'b01:   loadData = reqSigned_q ? {{16{loadHalf[15]}}, loadHalf} : {16'h0, loadHalf};
            default: loadData = rdWord_q;
        endcase
    end

    // Store word: replace only the target lane of the word read back.
    always_comb begin
        mergedWord = rdWord_q;
        case (reqSize_q)
            2'b00:   mergedWord[{byteOff_q, 3'b000} +: 8] = reqWdata_q[7:0];
            2'b01:   mergedWord[{byteOff_q[1], 4'b0000} +: 16] = reqWdata_q[15:0];
            default: mergedWord = reqWdata_q;
        endcase
    end

    // Reset also masks the outputs so a write in flight never lands.
    assign memAccess  = (state_q == READ || state_q == WRITE) && !rst;
    assign req_ready  = (state_q == IDLE);
    assign ram_ena    = memAccess;
    assign wena       = (state_q == WRITE) && !rst;
    assign addr       = memAccess ? wordAddr_q : '0;
    assign data_in    = wena ? mergedWord : 32'h0;
    assign resp_valid = (state_q == RESP) && !rst;
    assign resp_err   = resp_valid && reqErr_q;
    assign resp_rdata = (resp_valid && !reqWe_q && !reqErr_q) ? loadData : 32'h0;

endmodule

// File: tb/tb_dmem_access_master.sv
// Directed testbench for dmem_access_master with a behavioural dmem model.
module tb_dmem_access_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_ena;
    logic        wena;
    logic [9:0]  addr;
    logic [31:0] data_in;
    wire  [31:0] data_out;

    logic [31:0] mem [0:1023];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int wenaCount  = 0;
    int rdCycles   = 0;
    int ramEnaCount = 0;
    int respCount  = 0;
    int cycleCount = 0;
    logic [9:0]  lastWAddr = '0;
    logic [31:0] lastWData = '0;
    logic [31:0] respQ[$];

    dmem_access_master #(.WADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_ena    (ram_ena),
        .wena       (wena),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read memory; output floats when not enabled.
    assign data_out = ram_ena ? mem[addr] : 32'bz;

    // Writes land on the posedge; bookkeeping of dmem activity.
    always @(posedge clk) begin
        cycleCount = cycleCount + 1;
        if (ram_ena) ramEnaCount = ramEnaCount + 1;
        if (ram_ena && !wena) rdCycles = rdCycles + 1;
        if (ram_ena && wena) begin
            mem[addr] = data_in;
            wenaCount = wenaCount + 1;
            lastWAddr = addr;
            lastWData = data_in;
        end
        if (resp_valid) respCount = respCount + 1;
    end

    // Collect responses away from the clock edge.
    always @(negedge clk) begin
        if (resp_valid) respQ.push_back(resp_rdata);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one request from an idle DUT and hold it through the accept edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // One full request: latency in accept-edge terms, data, error, single pulse.
    task automatic doReq(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int expLat, input logic [31:0] expRdata, input logic expErr);
        int lat;
        logic [31:0] rd;
        logic er;
        applyStimulus(we, size, sgn, a, wd);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) lat = 99;
        rd = resp_rdata;
        er = resp_err;
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " rdata"}, rd, expRdata);
        checkOutput({tag, " err"}, {31'h0, er}, {31'h0, expErr});
        @(posedge clk);
        #1;
        checkOutput({tag, " pulse"}, {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        int w0, r0, e0, c0, waits;
        int acc[4];
        logic [31:0] loadAddr[4];
        logic [31:0] loadExp[4];

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("rst resp_err", {31'h0, resp_err}, 32'h0);
        checkOutput("rst ram_ena", {31'h0, ram_ena}, 32'h0);
        checkOutput("rst wena", {31'h0, wena}, 32'h0);
        checkOutput("rst addr", {22'h0, addr}, 32'h0);
        checkOutput("rst data_in", data_in, 32'h0);
        checkOutput("rst resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] word store then word load");
        w0 = wenaCount;
        doReq("sw 0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        checkOutput("sw wena cycles", 32'(wenaCount - w0), 32'd1);
        checkOutput("sw dmem addr", {22'h0, lastWAddr}, 32'd4);
        checkOutput("sw mem[4]", mem[4], 32'hDEADBEEF);
        doReq("lw 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        $display("[TB] byte store via read-modify-write");
        mem[4] = 32'h11223344;
        w0 = wenaCount;
        r0 = rdCycles;
        doReq("sb 0x12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, 3, 32'h0, 1'b0);
        checkOutput("sb read cycles", 32'(rdCycles - r0), 32'd1);
        checkOutput("sb wena cycles", 32'(wenaCount - w0), 32'd1);
        checkOutput("sb data_in", lastWData, 32'h11AB3344);
        doReq("lw after sb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h11AB3344, 1'b0);

        $display("[TB] sub-word loads with extension");
        mem[4] = 32'h8000F07F;
        doReq("lb 0x10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 32'h0000007F, 1'b0);
        doReq("lb 0x11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 32'hFFFFFFF0, 1'b0);
        doReq("lbu 0x13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'h00000080, 1'b0);
        doReq("lhu 0x12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 32'h00008000, 1'b0);
        doReq("lh 0x12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 32'hFFFF8000, 1'b0);

        $display("[TB] misaligned and reserved size");
        e0 = ramEnaCount;
        doReq("lw 0x13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        doReq("sh 0x11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 1, 32'h0, 1'b1);
        doReq("size 11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1);
        checkOutput("err ram_ena cycles", 32'(ramEnaCount - e0), 32'd0);
        checkOutput("err mem[4]", mem[4], 32'h8000F07F);

        $display("[TB] reset during write");
        mem[5] = 32'h55667788;
        c0 = respCount;
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234);
        @(posedge clk);
        #1;
        checkOutput("pre-rst wena", {31'h0, wena}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rst gates wena", {31'h0, wena}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("after rst req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("after rst mem[5]", mem[5], 32'h55667788);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("dropped resp", 32'(respCount - c0), 32'd0);

        $display("[TB] back-to-back loads with address wrap");
        mem[4] = 32'h0BADF00D;
        loadAddr[0] = 32'h1010; loadExp[0] = 32'h0BADF00D;
        loadAddr[1] = 32'h14;   loadExp[1] = 32'h55667788;
        loadAddr[2] = 32'h1014; loadExp[2] = 32'h55667788;
        loadAddr[3] = 32'h10;   loadExp[3] = 32'h0BADF00D;
        respQ.delete();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = loadAddr[i];
            acc[i] = -1;
            waits = 0;
            while (acc[i] < 0 && waits < 10) begin
                if (req_ready) begin
                    @(posedge clk);
                    #1;
                    acc[i] = cycleCount;
                end else begin
                    @(posedge clk);
                    #1;
                    waits++;
                end
            end
            checkOutput("busy req_ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) begin
            checkOutput("accept spacing", 32'(acc[i] - acc[i-1]), 32'd3);
        end
        checkOutput("b2b resp count", 32'(respQ.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("b2b rdata", (respQ.size() > i) ? respQ[i] : 32'hFFFFFFFF, loadExp[i]);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_access_master.md
Name: dmem_access_master

Overview:
- Initiator side of the data-memory port: converts CPU load/store requests (byte, halfword, word; signed or unsigned) into the word-only dmem protocol.
- dmem protocol: ram_ena, wena, 10-bit word addr, 32-bit data_in/data_out; reads are asynchronous, writes land on the posedge.
- Sub-word stores are done by read-modify-write (RMW).
- Sits between the MEM stage and dmem, and stalls the pipeline through req_ready.

Parameters:
- WADDR_W, 10, dmem word-address width; byte address bits [WADDR_W+1:2] form the word address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; requester holds all req_* stable until accepted.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at posedge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  32  byte address; bits above WADDR_W+1 ignored (address wraps).
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned or reserved size.
- ram_ena  out  1  dmem enable.
- wena  out  1  dmem write enable.
- addr  out  WADDR_W  dmem word address.
- data_in  out  32  dmem write data.
- data_out  in  32  dmem read data; hi-Z when ram_ena = 0, never sampled then.

Behaviour:
- States: IDLE, READ, WRITE, RESP. Request fields are latched on accept.
- Reset (synchronous): state = IDLE; req_ready = 1; resp_valid, resp_err, ram_ena, wena = 0; addr, data_in, resp_rdata = 0.
  - wena is gated with !rst, so a reset asserted during WRITE suppresses that dmem write.
  - A request in flight is dropped with no response.
- Endianness: little-endian. Byte offset k (addr[1:0]) maps to lane [8k+7:8k]; a halfword at offset 2 maps to [31:16].
- Misaligned: halfword with addr[0] = 1, word with addr[1:0] ≠ 0, or size 11.
  - IDLE → RESP with resp_err = 1.
  - No dmem access; ram_ena stays 0.
- Load: IDLE → READ → RESP.
  - READ: ram_ena = 1, wena = 0, addr = word address; data_out is registered at the end of the cycle.
  - RESP: resp_rdata = selected lane, extended per req_signed.
- Word store: IDLE → WRITE → RESP.
  - WRITE: ram_ena = 1, wena = 1, data_in = req_wdata.
- Sub-word store: IDLE → READ → WRITE → RESP.
  - data_in = registered read word with only the target lane replaced by req_wdata's low bits; the other bytes are preserved.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready is 0 in READ/WRITE/RESP.
- Latency from accept edge T (resp_valid high during the cycle after the listed edge):
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
  - error: T+1
- ram_ena = 0 in IDLE and RESP; dmem is never written outside WRITE.
- req_valid while req_ready = 0 is ignored (not queued).
- Back-to-back requests: a new request can be accepted in the cycle resp_valid falls (IDLE). No overlap between requests.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF, then word load 0x10 → wena high for exactly 1 cycle at dmem addr 4; load resp_rdata = 0xDEADBEEF at T+2, resp_err = 0.
- Mem[4] = 0x11223344; sb addr 0x12, wdata 0xAB → READ then WRITE with data_in = 0x11AB3344; resp at T+3; a later word load returns 0x11AB3344.
- Mem[4] = 0x8000F07F; lb 0x10 signed → 0x0000007F; lb 0x11 signed → 0xFFFFFFF0; lhu 0x12 → 0x00008000; lh 0x12 → 0xFFFF8000.
- lw 0x13, sh 0x11, and size 11 → resp_err = 1 at T+1, ram_ena never high, memory unchanged.
- sh 0x16, wdata 0x1234 with rst = 1 during WRITE → wena low at that edge, Mem[5] unchanged, no resp_valid, req_ready = 1 next cycle.
- req_valid held high for 4 consecutive loads → accepts every 3 cycles, req_ready low while busy; byte address 0x1010 wraps to word 4.
